pipe_arbiter: RTL and testbench
===============================

PIPE_ARBITER -- requirements
Module: pipe_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the unit (2..8).
REQ-002 Parameter LATENCY, default 3: fixed cycles from unit_valid_out to matching unit_result_in (>=1).
REQ-003 Parameter WIDTH, default 16: request operand width.
REQ-004 Parameter RWIDTH, default 16: result width.
REQ-005 clk_in  input  1  sole clock; all logic on posedge.
REQ-006 rst_n_in  input  1  synchronous, active-low reset.
REQ-007 req_valid_in  input  NUM_REQ  per-requester request valid.
REQ-008 req_data_in  input  NUM_REQ x WIDTH  per-requester operand.
REQ-009 req_ready_out  output  NUM_REQ  one-hot grant; request i accepted when req_valid_in[i] & req_ready_out[i].
REQ-010 unit_valid_out  output  1  operand issue strobe to the shared pipelined unit.
REQ-011 unit_data_out  output  WIDTH  operand to the unit.
REQ-012 unit_result_in  input  RWIDTH  unit result; valid exactly LATENCY cycles after unit_valid_out.
REQ-013 resp_valid_out  output  NUM_REQ  one-hot, one-cycle response strobe to the owning requester.
REQ-014 resp_data_out  output  RWIDTH  result, shared bus, qualified by resp_valid_out.
REQ-015 flush_in  input  1  drain request pulse.
REQ-016 flush_done_out  output  1  one-cycle pulse when drain complete.
REQ-017 busy_out  output  1  high while any transaction is in flight.

Function
REQ-018 req_ready_out SHALL be combinational: at most one bit set, only in state RUN, only for a requester with req_valid_in high.
REQ-019 Arbitration SHALL be round-robin: search starts at pointer p, wraps NUM_REQ-1 -> 0; after accepting requester i, p <= (i+1) mod NUM_REQ; p unchanged on cycles with no accept.
REQ-020 Accept in cycle t SHALL drive unit_valid_out=1 and unit_data_out=req_data_in[i] in cycle t+1 (registered); unit_valid_out=0 otherwise, unit_data_out holds last value.
REQ-021 Requester ID SHALL travel through a valid+ID delay line aligned with the unit; in cycle t+1+LATENCY unit_result_in is sampled.
REQ-022 resp_valid_out[i] and resp_data_out SHALL be registered, asserted in cycle t+2+LATENCY for one cycle; resp_data_out holds last value otherwise.
REQ-023 Throughput SHALL be one accept per cycle; back-to-back accepts yield back-to-back responses in accept order.
REQ-024 In-flight counter (width clog2(LATENCY+3)) SHALL increment on accept, decrement on response, remain unchanged on simultaneous accept and response; busy_out = (count != 0).
REQ-025 FSM states RUN, DRAIN, DONE: RUN -> DRAIN on flush_in; DRAIN -> DONE when count==0 and no accept pending; DONE -> RUN unconditionally after one cycle.
REQ-026 flush_in in RUN SHALL block accepts starting the same cycle (req_ready_out all 0); flush_in in DRAIN or DONE SHALL be ignored.
REQ-027 flush_done_out SHALL equal (state==DONE); flush with empty pipeline SHALL give DRAIN one cycle, flush_done_out in cycle t+2 after flush_in at t.
REQ-028 Responses in flight during DRAIN SHALL still be delivered normally.

Reset
REQ-029 When rst_n_in=0 at a clock edge: state=RUN, p=0, count=0, delay line valids=0, unit_valid_out=0, resp_valid_out=0, flush_done_out=0, unit_data_out=0, resp_data_out=0.
REQ-030 Reset mid-operation SHALL discard all in-flight transactions; no response for them after reset deasserts.
REQ-031 req_ready_out SHALL be 0 while rst_n_in=0.

Structure
REQ-032 Package pipe_arb_pkg SHALL hold the FSM state enum (RUN, DRAIN, DONE) and a clog2-based counter width function.
REQ-033 Round-robin grant logic SHALL be a sub-module rr_arbiter (NUM_REQ; inputs req, pointer; output one-hot grant, granted index).
REQ-034 Delay line SHALL be LATENCY+1 stages of {valid, ID}, no data stored.

Verification
REQ-035 Single: LATENCY=3, req 2 valid with data 0x00AB at t -> unit_valid_out/0x00AB at t+1; bench unit returns 0x1234 at t+4 -> resp_valid_out=4'b0100, resp_data 0x1234 at t+5.
REQ-036 Fairness: all 4 requesters valid continuously from reset -> grants 0,1,2,3,0,1... one per cycle, responses in same order.
REQ-037 Wrap: p=3, only requesters 1 and 3 valid -> grant 3 then 1.
REQ-038 Flush: 3 accepts at t..t+2, flush_in at t+2 -> t+2 not accepted; flush_done_out at t+6 (LATENCY=3); busy_out low at t+6.
REQ-039 Reset mid-flight: 2 accepts then rst_n_in low 1 cycle -> no resp_valid_out afterwards, busy_out=0, next grant starts at requester 0.
REQ-040 Idle flush: flush_in at t with empty pipe -> flush_done_out at t+2 only; accept resumes at t+3.

Source files
------------

// File: rtl/pipe_arb_pkg.sv
// Shared types for the pipelined-unit arbiter.
// FSM state enum and in-flight counter width helper.
package pipe_arb_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    DONE
  } arb_state_e;

  function automatic int cnt_width(input int lat);
    return $clog2(lat + 3);
  endfunction

endpackage

// File: rtl/pipe_arbiter_rr.sv
// Round-robin grant: first set req bit at or after ptr, wrapping.
// Ports: req, ptr in; one-hot grant and its index out.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IW = $clog2(NUM_REQ);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/pipe_arbiter.sv
// Shares one fixed-latency pipelined unit among NUM_REQ requesters.
// Ports: req valid/data/ready, unit issue/result, resp, flush, busy.
module pipe_arbiter
  import pipe_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 3,
  parameter int WIDTH   = 16,
  parameter int RWIDTH  = 16
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ-1:0][WIDTH-1:0] req_data_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic                          unit_valid_out,
  output logic [WIDTH-1:0]              unit_data_out,
  input  logic [RWIDTH-1:0]             unit_result_in,
  output logic [NUM_REQ-1:0]            resp_valid_out,
  output logic [RWIDTH-1:0]             resp_data_out,
  input  logic                          flush_in,
  output logic                          flush_done_out,
  output logic                          busy_out
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(LATENCY);

  arb_state_e state, state_nx;

  logic [IW-1:0]      ptr;
  logic [IW-1:0]      gidx;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic               accept;
  logic               retire;
  logic [CW-1:0]      cnt;

  logic [LATENCY:0]         dl_v;
  logic [LATENCY:0][IW-1:0] dl_id;

  // A flush raised this cycle already blocks grants.
  assign elig = (rst_n_in && state == RUN && !flush_in)
              ? req_valid_in : '0;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .req  (elig),
    .ptr  (ptr),
    .grant(grant),
    .idx  (gidx)
  );

  assign req_ready_out  = grant;
  assign accept         = |grant;
  assign retire         = dl_v[LATENCY];
  assign busy_out       = (cnt != '0);
  assign flush_done_out = (state == DONE);

  // Drain ends once the last in-flight result is being retired.
  always_comb begin
    state_nx = state;
    unique case (state)
      RUN:     if (flush_in) state_nx = DRAIN;
      DRAIN:   if (cnt == CW'(retire)) state_nx = DONE;
      DONE:    state_nx = RUN;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state          <= RUN;
      ptr            <= '0;
      cnt            <= '0;
      dl_v           <= '0;
      dl_id          <= '0;
      unit_valid_out <= 1'b0;
      unit_data_out  <= '0;
      resp_valid_out <= '0;
      resp_data_out  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        ptr <= (gidx == IW'(NUM_REQ - 1))
             ? '0 : gidx + 1'b1;
        unit_data_out <= req_data_in[gidx];
      end
      unit_valid_out <= accept;
      dl_v  <= {dl_v[LATENCY-1:0], accept};
      dl_id <= {dl_id[LATENCY-1:0], gidx};
      resp_valid_out <= retire
                      ? NUM_REQ'(1) << dl_id[LATENCY]
                      : '0;
      if (retire) resp_data_out <= unit_result_in;
      unique case ({accept, retire})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_arbiter.sv
// Self-checking bench for pipe_arbiter with a cycle-indexed model.
// Directed scenarios first, then randomized traffic.
module tb_pipe_arbiter;

  localparam int L  = 3;
  localparam int NC = 1500;
  localparam int NA = NC + 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req_valid;
  logic [3:0][15:0] req_data;
  logic [3:0]       ready;
  logic             uv;
  logic [15:0]      ud;
  logic [15:0]      ures;
  logic [3:0]       rv;
  logic [15:0]      rd;
  logic             flush;
  logic             fdone;
  logic             busy;

  always #5 clk = ~clk;

  pipe_arbiter #(
    .NUM_REQ(4),
    .LATENCY(L),
    .WIDTH  (16),
    .RWIDTH (16)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .req_valid_in  (req_valid),
    .req_data_in   (req_data),
    .req_ready_out (ready),
    .unit_valid_out(uv),
    .unit_data_out (ud),
    .unit_result_in(ures),
    .resp_valid_out(rv),
    .resp_data_out (rd),
    .flush_in      (flush),
    .flush_done_out(fdone),
    .busy_out      (busy)
  );

  logic [15:0] res_drv [0:NA-1];
  logic        e_uv    [0:NA-1];
  logic [15:0] e_ud    [0:NA-1];
  logic [3:0]  e_rv    [0:NA-1];
  logic [15:0] e_rd    [0:NA-1];

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          mp, last_resp, drain_from, done_at, ai;
  logic [15:0] m_ud, m_rd;
  logic [3:0]  x_rdy;
  logic        running;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s cyc=%0d got=%h exp=%h",
                 nm, cyc, act, exp);
    end
  endtask

  function automatic logic [3:0] rr_pick(input logic [3:0] v,
                                         input int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return 4'b0001 << ((p + k) % 4);
    return 4'b0000;
  endfunction

  initial begin
    for (int i = 0; i < NA; i++) begin
      res_drv[i] = 16'($urandom);
      e_uv[i] = 1'b0; e_ud[i] = '0;
      e_rv[i] = '0;   e_rd[i] = '0;
    end
    res_drv[8] = 16'h1234;
    rst_n = 1'b0; req_valid = '0; req_data = '0;
    flush = 1'b0; ures = '0;
    mp = 0; last_resp = -1; drain_from = -1; done_at = -1;
    m_ud = '0; m_rd = '0;

    for (int c = 0; c < NC; c++) begin
      @(posedge clk); #1;
      cyc = c;
      rst_n = !(c < 2 || c == 16 ||
                (c >= 50 && $urandom_range(199) == 0));
      req_data  = {$urandom, $urandom};
      req_valid = '0;
      flush     = 1'b0;
      if (c == 4) begin
        req_valid   = 4'b0100;
        req_data[2] = 16'h00AB;
      end
      if (c == 12 || c == 13) req_valid = 4'b1010;
      if (c >= 17 && c <= 35) req_valid = 4'b1111;
      if (c == 30 || c == 42) flush = 1'b1;
      if (c == 44 || c == 45) req_valid = 4'b1111;
      if (c >= 50) begin
        req_valid = 4'($urandom);
        flush     = ($urandom_range(24) == 0);
      end
      ures = res_drv[c];
      #1;

      if (e_uv[c]) m_ud = e_ud[c];
      if (e_rv[c] != '0) m_rd = e_rd[c];
      running = !(c >= drain_from && c <= done_at);
      x_rdy = (rst_n && running && !flush)
            ? rr_pick(req_valid, mp) : 4'b0000;

      chk("ready", ready, x_rdy);
      if (c >= 1) begin
        chk("unit_valid", uv, e_uv[c]);
        chk("unit_data", ud, m_ud);
        chk("resp_valid", rv, e_rv[c]);
        chk("resp_data", rd, m_rd);
        chk("busy", busy, last_resp > c);
        chk("flush_done", fdone, c == done_at);
      end

      if (c == 2) begin
        chk("lit_rst_uv", uv, 0);
        chk("lit_rst_ud", ud, 0);
        chk("lit_rst_rv", rv, 0);
        chk("lit_rst_rd", rd, 0);
        chk("lit_rst_busy", busy, 0);
        chk("lit_rst_fdone", fdone, 0);
      end
      if (c == 4)  chk("lit_single_rdy", ready, 4'b0100);
      if (c == 5) begin
        chk("lit_single_uv", uv, 1);
        chk("lit_single_ud", ud, 16'h00AB);
      end
      if (c == 9) begin
        chk("lit_single_rv", rv, 4'b0100);
        chk("lit_single_rd", rd, 16'h1234);
      end
      if (c == 12) chk("lit_wrap_3", ready, 4'b1000);
      if (c == 13) chk("lit_wrap_1", ready, 4'b0010);
      if (c == 17) begin
        chk("lit_rst_grant0", ready, 4'b0001);
        chk("lit_rst_norv", rv, 0);
        chk("lit_rst_nobusy", busy, 0);
      end
      if (c == 18) begin
        chk("lit_fair_1", ready, 4'b0010);
        chk("lit_rst_norv2", rv, 0);
      end
      if (c == 20) chk("lit_fair_3", ready, 4'b1000);
      if (c == 21) chk("lit_fair_0", ready, 4'b0001);
      if (c == 22) chk("lit_fair_rv0", rv, 4'b0001);
      if (c == 23) chk("lit_fair_rv1", rv, 4'b0010);
      if (c == 30) chk("lit_flush_block", ready, 0);
      if (c == 33) chk("lit_flush_nd", fdone, 0);
      if (c == 34) begin
        chk("lit_flush_done", fdone, 1);
        chk("lit_flush_idle", busy, 0);
      end
      if (c == 35) chk("lit_flush_resume", ready, 4'b0010);
      if (c == 43) chk("lit_idle_nd", fdone, 0);
      if (c == 44) begin
        chk("lit_idle_done", fdone, 1);
        chk("lit_idle_block", ready, 0);
      end
      if (c == 45) begin
        chk("lit_idle_resume", ready, 4'b0100);
        chk("lit_idle_nd2", fdone, 0);
      end

      if (!rst_n) begin
        for (int k = c + 1; k < c + L + 4 && k < NA; k++) begin
          e_uv[k] = 1'b0;
          e_rv[k] = '0;
        end
        m_ud = '0; m_rd = '0;
        mp = 0; last_resp = -1;
        drain_from = -1; done_at = -1;
      end else begin
        if (x_rdy != '0) begin
          ai = 0;
          for (int b = 0; b < 4; b++) if (x_rdy[b]) ai = b;
          e_uv[c+1]   = 1'b1;
          e_ud[c+1]   = req_data[ai];
          e_rv[c+2+L] = x_rdy;
          e_rd[c+2+L] = res_drv[c+1+L];
          last_resp   = c + 2 + L;
          mp          = (ai + 1) % 4;
        end
        if (flush && running) begin
          drain_from = c + 1;
          done_at = (last_resp > c + 2) ? last_resp : c + 2;
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
